// File: rtl/seven_seg_rx.sv
// Receiver for a two-digit multiplexed seven-segment bus: filters bus glitches,
// decodes glyphs to hex nibbles and assembles high/low pairs with staleness timeout.
module seven_seg_rx #(
  parameter int STABLE_CYCLES = 16,
  parameter int TIMEOUT       = 4096
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] seg_in,
  output logic [7:0] dout,
  output logic       valid,
  output logic       upd,
  output logic       err
);

  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_PRE = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1'b1);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]   TO_PRE   = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]   TO_ONE   = TO_W'(1'b1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GOT_HI = 2'd1,
    S_GOT_LO = 2'd2
  } state_t;

  // Returns {error, nibble}; segments arrive active-low, so invert before lookup.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg_n);
    logic [6:0] pat;
    pat = ~seg_n;
    case (pat)
      7'h3F:   decode_glyph = 5'h00;
      7'h06:   decode_glyph = 5'h01;
      7'h5B:   decode_glyph = 5'h02;
      7'h4F:   decode_glyph = 5'h03;
      7'h66:   decode_glyph = 5'h04;
      7'h6D:   decode_glyph = 5'h05;
      7'h7D:   decode_glyph = 5'h06;
      7'h07:   decode_glyph = 5'h07;
      7'h7F:   decode_glyph = 5'h08;
      7'h6F:   decode_glyph = 5'h09;
      7'h77:   decode_glyph = 5'h0A;
      7'h7C:   decode_glyph = 5'h0B;
      7'h39:   decode_glyph = 5'h0C;
      7'h5E:   decode_glyph = 5'h0D;
      7'h79:   decode_glyph = 5'h0E;
      7'h71:   decode_glyph = 5'h0F;
      default: decode_glyph = 5'h10;
    endcase
  endfunction

  logic [7:0]        r_seg_q;
  logic [STAB_W-1:0] r_stab;
  logic [TO_W-1:0]   r_to;
  state_t            r_state;
  logic [4:0]        r_hi;
  logic [4:0]        r_lo;

  logic       w_changed;
  logic       w_capture;
  logic       w_timeout;
  logic       w_sel;
  logic [4:0] w_dec;

  assign w_changed = (seg_in != r_seg_q);
  assign w_capture = !w_changed && (r_stab == STAB_PRE);
  assign w_timeout = !w_capture && (r_to == TO_PRE);
  assign w_sel     = r_seg_q[7];
  assign w_dec     = decode_glyph(r_seg_q[6:0]);

  // Reset value is a blank low digit so the first real pattern registers as a change.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_seg_q <= 8'hFF;
      r_stab  <= '0;
      r_to    <= '0;
    end else begin
      r_seg_q <= seg_in;
      if (w_changed) begin
        r_stab <= '0;
      end else if (r_stab != STAB_MAX) begin
        r_stab <= r_stab + STAB_ONE;
      end else begin
        r_stab <= r_stab;
      end
      if (w_capture) begin
        r_to <= '0;
      end else if (r_to != TO_MAX) begin
        r_to <= r_to + TO_ONE;
      end else begin
        r_to <= r_to;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_hi    <= 5'h00;
      r_lo    <= 5'h00;
      dout    <= 8'h00;
      valid   <= 1'b0;
      upd     <= 1'b0;
      err     <= 1'b0;
    end else begin
      upd <= 1'b0;
      if (w_capture) begin
        case (r_state)
          S_IDLE: begin
            if (!w_sel) begin
              r_hi    <= w_dec;
              r_state <= S_GOT_HI;
            end else begin
              r_lo    <= w_dec;
              r_state <= S_GOT_LO;
            end
          end
          S_GOT_HI: begin
            if (!w_sel) begin
              r_hi <= w_dec;
            end else begin
              dout    <= {r_hi[3:0], w_dec[3:0]};
              err     <= r_hi[4] | w_dec[4];
              valid   <= 1'b1;
              upd     <= 1'b1;
              r_hi    <= 5'h00;
              r_lo    <= 5'h00;
              r_state <= S_IDLE;
            end
          end
          S_GOT_LO: begin
            if (w_sel) begin
              r_lo <= w_dec;
            end else begin
              dout    <= {w_dec[3:0], r_lo[3:0]};
              err     <= w_dec[4] | r_lo[4];
              valid   <= 1'b1;
              upd     <= 1'b1;
              r_hi    <= 5'h00;
              r_lo    <= 5'h00;
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_hi    <= 5'h00;
            r_lo    <= 5'h00;
            r_state <= S_IDLE;
          end
        endcase
      end else if (w_timeout) begin
        // Stale: drop any half-built pair but keep the last value visible.
        valid   <= 1'b0;
        r_hi    <= 5'h00;
        r_lo    <= 5'h00;
        r_state <= S_IDLE;
      end else begin
        r_state <= r_state;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_rx.sv
// Directed bench for seven_seg_rx: glitch filtering, pairing, bad glyphs,
// timeout, same-select overwrite and reset mid-pair.
module tb_seven_seg_rx;

  logic       CLK;
  logic       RST;
  logic [7:0] seg_in;
  logic [7:0] dout;
  logic       valid;
  logic       upd;
  logic       err;

  int total = 0;
  int bad   = 0;
  int upd_cnt = 0;

  seven_seg_rx #(
    .STABLE_CYCLES(16),
    .TIMEOUT(64)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .seg_in(seg_in),
    .dout(dout),
    .valid(valid),
    .upd(upd),
    .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (upd === 1'b1) upd_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive v for n edges; report the edge index (1-based) of the first upd, or 0.
  task automatic hold(input logic [7:0] v, input int n, output int first_upd);
    seg_in = v;
    first_upd = 0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (upd === 1'b1 && first_upd == 0) first_upd = k;
    end
  endtask

  int f;
  int base;
  int fell;
  int seen_valid;

  initial begin
    RST = 1'b1;
    seg_in = 8'hFF;
    repeat (3) tick();
    check_eq("rst_dout", dout, 8'h00);
    check_eq("rst_valid", valid, 1'b0);
    check_eq("rst_upd", upd, 1'b0);
    check_eq("rst_err", err, 1'b0);
    RST = 1'b0;

    // Basic pair: low '1' then high '2'
    base = upd_cnt;
    hold(8'hF9, 32, f);
    check_eq("t26_no_upd_lo", f, 0);
    hold(8'h24, 32, f);
    check_eq("t26_upd_edge", f, 17);
    check_eq("t26_upd_cnt", upd_cnt - base, 1);
    check_eq("t26_dout", dout, 8'h21);
    check_eq("t26_valid", valid, 1'b1);
    check_eq("t26_err", err, 1'b0);

    // Glitch burst shorter than the stability window
    base = upd_cnt;
    hold(8'hF9, 10, f);
    hold(8'h24, 32, f);
    check_eq("t27_no_upd_hi", f, 0);
    hold(8'hF9, 32, f);
    check_eq("t27_upd_edge", f, 17);
    check_eq("t27_upd_cnt", upd_cnt - base, 1);
    check_eq("t27_dout", dout, 8'h21);

    // Blank low digit is an unrecognised glyph
    base = upd_cnt;
    hold(8'hFF, 32, f);
    hold(8'h40, 32, f);
    check_eq("t28_upd_cnt", upd_cnt - base, 1);
    check_eq("t28_dout", dout, 8'h00);
    check_eq("t28_err", err, 1'b1);
    check_eq("t28_valid", valid, 1'b1);

    // Timeout 64 edges after the pair-completing capture
    hold(8'hF9, 32, f);
    hold(8'h24, 17, f);
    check_eq("t29_cap_edge", f, 17);
    fell = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (valid !== 1'b1 && fell == 0) fell = k;
    end
    check_eq("t29_fall_edge", fell, 64);
    check_eq("t29_dout_held", dout, 8'h21);
    check_eq("t29_err_held", err, 1'b0);
    hold(8'h92, 32, f);
    hold(8'h10, 32, f);
    check_eq("t29_fresh_valid", valid, 1'b1);
    check_eq("t29_fresh_dout", dout, 8'h95);

    // Same-select overwrite; 0x78 is '7' on the high select
    base = upd_cnt;
    hold(8'h24, 32, f);
    hold(8'hFF, 8, f);
    hold(8'h78, 32, f);
    hold(8'hF9, 32, f);
    check_eq("t30_upd_cnt", upd_cnt - base, 1);
    check_eq("t30_dout", dout, 8'h71);
    check_eq("t30_err", err, 1'b0);

    // Reset mid-pair, then only a low digit
    hold(8'h24, 32, f);
    RST = 1'b1;
    #1;
    check_eq("t31_async_valid", valid, 1'b0);
    check_eq("t31_async_dout", dout, 8'h00);
    tick();
    seg_in = 8'hF9;
    RST = 1'b0;
    base = upd_cnt;
    seen_valid = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (valid === 1'b1) seen_valid = 1;
    end
    check_eq("t31_upd_cnt", upd_cnt - base, 0);
    check_eq("t31_valid_seen", seen_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
